vector_edge_monitor: RTL and testbench
======================================

VECTOR_EDGE_MONITOR -- requirements
Module: vector_edge_monitor

Interface
REQ-001 Parameter WIDTH, default 4, width of the monitored vector.
REQ-002 Parameter DEPTH, default 4, event-queue entries; power of two, >= 2.
REQ-003 Parameter CNT_W, default 8, width of the rise-event counter.
REQ-004 clk  input  1  sole clock; all logic samples on its rising edge.
REQ-005 rst_n  input  1  synchronous reset, active-low.
REQ-006 sig_in  input  WIDTH  monitored vector, sampled every rising edge of clk.
REQ-007 clr_i  input  1  synchronous clear of queue, counter and overflow flag.
REQ-008 rise_o  output  WIDTH  per-bit rising-edge mask.
REQ-009 fall_o  output  WIDTH  per-bit falling-edge mask.
REQ-010 any_rise_o  output  1  OR-reduction of the rise mask.
REQ-011 any_fall_o  output  1  OR-reduction of the fall mask.
REQ-012 rise_cnt_o  output  CNT_W  saturating count of cycles with any rise.
REQ-013 evt_valid_o  output  1  the event queue is non-empty.
REQ-014 evt_ready_i  input  1  consumer accepts the head entry.
REQ-015 evt_data_o  output  2*WIDTH  head entry, {rise_mask, fall_mask}.
REQ-016 evt_overflow_o  output  1  sticky flag; an event was dropped.

Function
REQ-017 A sample register SHALL capture sig_in every cycle. A prev_valid flag SHALL be set on the first cycle after reset.
REQ-018 Per-bit rise SHALL be 4-state: previous sample !== 1 (0, x or z) and current === 1. Per-bit fall SHALL be: previous !== 0 and current === 0.
REQ-019 Edges SHALL be evaluated independently on every bit. Edge detection SHALL NOT be restricted to the LSB.
REQ-020 rise_o and fall_o SHALL be registered. For the comparison of samples N-1 and N, the masks SHALL be visible after edge N, giving 1-cycle latency from the sig_in change.
REQ-021 While prev_valid=0, rise_o and fall_o SHALL be forced to 0.
REQ-022 any_rise_o and any_fall_o SHALL be registered in the same cycle as the masks.
REQ-023 rise_cnt_o SHALL increment by 1 per cycle in which the rise mask is non-zero. It SHALL saturate at all-ones and SHALL NOT wrap.
REQ-024 An event (nonzero {rise, fall}) SHALL push {rise_mask, fall_mask} into a DEPTH-entry FIFO in the cycle the masks are registered.
REQ-025 The FIFO SHALL be first-word-fall-through. evt_data_o SHALL show the head entry whenever evt_valid_o=1.
REQ-026 A pop SHALL occur when evt_valid_o && evt_ready_i. evt_data_o SHALL be don't-care while evt_valid_o=0.
REQ-027 Full with push and no pop: the new event SHALL be dropped, evt_overflow_o SHALL be set, and queue contents SHALL be unchanged.
REQ-028 Full with push and pop in the same cycle: both SHALL occur, occupancy SHALL stay DEPTH, and no overflow SHALL be flagged.
REQ-029 Empty with push: the entry SHALL appear with evt_valid_o=1 on the next cycle. A pop SHALL NOT occur in the same cycle.
REQ-030 Occupancy SHALL be tracked with a DEPTH+1-range counter. Pointers SHALL wrap modulo DEPTH.
REQ-031 clr_i=1 SHALL empty the queue and zero rise_cnt_o and evt_overflow_o. A push coinciding with clr_i SHALL be discarded.
REQ-032 clr_i SHALL NOT affect the sample register, prev_valid, rise_o or fall_o.
REQ-033 rst_n SHALL take priority over clr_i, and clr_i SHALL take priority over push and pop.

Reset
REQ-034 On a clk edge with rst_n=0, all of the following SHALL be 0: rise_o, fall_o, any_rise_o, any_fall_o, rise_cnt_o, evt_valid_o, evt_overflow_o, FIFO occupancy, pointers, prev_valid and the sample register.
REQ-035 Reset asserted mid-operation SHALL discard queued events and counts.
REQ-036 The first post-reset cycle SHALL report no edge, whatever the pre-reset sig_in value was.
REQ-037 No asynchronous path from rst_n to any output SHALL exist.

Verification
REQ-038 sig_in 4'b1000 -> 4'b1001 after reset -> next cycle: rise_o=0001, fall_o=0000, rise_cnt_o=1, evt_data_o=8'b0001_0000.
REQ-039 4'b1011 -> 4'b1010 -> fall_o=0001, any_fall_o=1, any_rise_o=0, rise_cnt_o unchanged.
REQ-040 4'b101x -> 4'b1111 -> rise_o=0101 (x->1 on bit0 counts); then 4'b1111 -> 4'b111z -> rise_o=0000, fall_o=0000.
REQ-041 evt_ready_i=0 with DEPTH=4 and 5 consecutive edge cycles -> 4 entries held, evt_overflow_o=1; then evt_ready_i=1 -> the first 4 events drain in order and evt_valid_o falls.
REQ-042 Queue full, edge cycle with evt_ready_i=1 -> occupancy stays 4, evt_overflow_o stays 0.
REQ-043 Toggling sig_in every cycle and asserting rst_n=0 for 1 cycle -> all outputs 0 after that edge; no edge reported on the first cycle after release; 300 rise cycles with CNT_W=8 -> rise_cnt_o holds 255.

Source files
------------

// File: rtl/vector_edge_monitor.sv
// Per-bit rising/falling edge monitor with registered masks, a saturating
// rise counter and a first-word-fall-through event queue with overflow flag.
module vector_edge_monitor #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   sig_in,
    input  logic               clr_i,
    output logic [WIDTH-1:0]   rise_o,
    output logic [WIDTH-1:0]   fall_o,
    output logic               any_rise_o,
    output logic               any_fall_o,
    output logic [CNT_W-1:0]   rise_cnt_o,
    output logic               evt_valid_o,
    input  logic               evt_ready_i,
    output logic [2*WIDTH-1:0] evt_data_o,
    output logic               evt_overflow_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

    logic [WIDTH-1:0]   sample_q, sample_d;
    logic               prev_valid_q, prev_valid_d;
    logic [WIDTH-1:0]   rise_q, rise_d;
    logic [WIDTH-1:0]   fall_q, fall_d;
    logic               any_rise_q, any_rise_d;
    logic               any_fall_q, any_fall_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]      occ_q, occ_d;
    logic               ovf_q, ovf_d;
    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [2*WIDTH-1:0] mem_d [DEPTH];

    logic [WIDTH-1:0]   edge_rise;
    logic [WIDTH-1:0]   edge_fall;
    logic               push;
    logic               pop;
    logic               full;
    logic               do_push;

    // 4-state compare: an x or z previous sample counts as "not 1"/"not 0"
    always_comb begin
        edge_rise = '0;
        edge_fall = '0;
        for (int i = 0; i < WIDTH; i++) begin
            edge_rise[i] = (sample_q[i] !== 1'b1) && (sig_in[i] === 1'b1);
            edge_fall[i] = (sample_q[i] !== 1'b0) && (sig_in[i] === 1'b0);
        end
    end

    always_comb begin
        sample_d     = sig_in;
        prev_valid_d = 1'b1;
        rise_d       = prev_valid_q ? edge_rise : '0;
        fall_d       = prev_valid_q ? edge_fall : '0;
        any_rise_d   = |rise_d;
        any_fall_d   = |fall_d;
    end

    assign push = |{rise_d, fall_d};
    assign full = (occ_q == FULL_OCC);
    assign pop  = evt_valid_o && evt_ready_i;
    assign do_push = push && (!full || pop);

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        ovf_d    = ovf_q;
        mem_d    = mem_q;
        if (clr_i) begin
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (|rise_d && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (push && full && !pop) begin
                ovf_d = 1'b1;
            end
            if (do_push) begin
                mem_d[wr_ptr_q] = {rise_d, fall_d};
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({do_push, pop})
                2'b10:   occ_d = occ_q + OW'(1);
                2'b01:   occ_d = occ_q - OW'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_q     <= '0;
            prev_valid_q <= 1'b0;
            rise_q       <= '0;
            fall_q       <= '0;
            any_rise_q   <= 1'b0;
            any_fall_q   <= 1'b0;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            ovf_q        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sample_q     <= sample_d;
            prev_valid_q <= prev_valid_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            any_rise_q   <= any_rise_d;
            any_fall_q   <= any_fall_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            ovf_q        <= ovf_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rise_o         = rise_q;
    assign fall_o         = fall_q;
    assign any_rise_o     = any_rise_q;
    assign any_fall_o     = any_fall_q;
    assign rise_cnt_o     = cnt_q;
    assign evt_valid_o    = (occ_q != '0);
    assign evt_data_o     = mem_q[rd_ptr_q];
    assign evt_overflow_o = ovf_q;

endmodule

// File: tb/tb_vector_edge_monitor.sv
// Randomised and directed checks of vector_edge_monitor against a
// queue-based reference model.
module tb_vector_edge_monitor;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] sig_in;
    logic             clr_i;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
    logic             any_rise_o;
    logic             any_fall_o;
    logic [CNT_W-1:0] rise_cnt_o;
    logic             evt_valid_o;
    logic             evt_ready_i;
    logic [7:0]       evt_data_o;
    logic             evt_overflow_o;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    logic [WIDTH-1:0] m_prev;
    bit               m_pv;
    logic [7:0]       m_q[$];
    int               m_cnt;
    bit               m_ovf;
    logic [WIDTH-1:0] m_rise;
    logic [WIDTH-1:0] m_fall;

    vector_edge_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sig_in(sig_in),
        .clr_i(clr_i),
        .rise_o(rise_o),
        .fall_o(fall_o),
        .any_rise_o(any_rise_o),
        .any_fall_o(any_fall_o),
        .rise_cnt_o(rise_cnt_o),
        .evt_valid_o(evt_valid_o),
        .evt_ready_i(evt_ready_i),
        .evt_data_o(evt_data_o),
        .evt_overflow_o(evt_overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model, then sample after the edge
    task automatic cycle(input logic [3:0] s, input bit c, input bit r, input bit rs);
        logic [3:0] er;
        logic [3:0] ef;
        bit pop;
        sig_in = s;
        clr_i = c;
        evt_ready_i = r;
        rst_n = rs;
        if (!rs) begin
            m_q.delete();
            m_cnt = 0;
            m_ovf = 0;
            m_pv = 0;
            m_prev = '0;
            m_rise = '0;
            m_fall = '0;
        end else begin
            er = '0;
            ef = '0;
            if (m_pv) begin
                for (int i = 0; i < WIDTH; i++) begin
                    er[i] = (m_prev[i] !== 1'b1) && (s[i] === 1'b1);
                    ef[i] = (m_prev[i] !== 1'b0) && (s[i] === 1'b0);
                end
            end
            pop = (m_q.size() != 0) && r;
            if (c) begin
                m_q.delete();
                m_cnt = 0;
                m_ovf = 0;
            end else begin
                if (pop) void'(m_q.pop_front());
                if ({er, ef} != 8'h00) begin
                    if (m_q.size() < DEPTH) m_q.push_back({er, ef});
                    else m_ovf = 1;
                end
                if (er != 4'h0 && m_cnt < 255) m_cnt++;
            end
            m_rise = er;
            m_fall = ef;
            m_prev = s;
            m_pv = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(4'($urandom()), 0, 0, 1);
        cycle(4'b1111, 0, 0, 0);
        n_vec++;
        if ({rise_o, fall_o, any_rise_o, any_fall_o} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_masks got %b/%b want 0", rise_o, fall_o);
        end
        n_vec++;
        if ({rise_cnt_o, evt_valid_o, evt_overflow_o} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_state got cnt=%0d v=%b o=%b want 0", rise_cnt_o, evt_valid_o, evt_overflow_o);
        end
        cycle(4'b0000, 0, 0, 1);
        n_vec++;
        if ({rise_o, fall_o} !== 8'b0) begin
            n_bad++;
            $display("FAIL reset_first_cycle got %b/%b want 0000/0000", rise_o, fall_o);
        end
    endtask

    task automatic test_directed();
        cycle(4'b0000, 0, 0, 0);
        cycle(4'b1000, 0, 0, 1);
        cycle(4'b1001, 0, 0, 1);
        n_vec++;
        if (rise_o !== 4'b0001 || fall_o !== 4'b0000) begin
            n_bad++;
            $display("FAIL dir_rise got %b/%b want 0001/0000", rise_o, fall_o);
        end
        n_vec++;
        if (rise_cnt_o !== 8'd1 || evt_data_o !== 8'b0001_0000 || evt_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL dir_cnt_evt got cnt=%0d data=%b v=%b want 1 00010000 1", rise_cnt_o, evt_data_o, evt_valid_o);
        end
        cycle(4'b1011, 0, 1, 1);
        cycle(4'b1010, 0, 1, 1);
        n_vec++;
        if (fall_o !== 4'b0001 || any_fall_o !== 1'b1 || any_rise_o !== 1'b0 || rise_cnt_o !== 8'd2) begin
            n_bad++;
            $display("FAIL dir_fall got f=%b af=%b ar=%b cnt=%0d want 0001 1 0 2", fall_o, any_fall_o, any_rise_o, rise_cnt_o);
        end
        cycle(4'b101x, 0, 1, 1);
        cycle(4'b1111, 0, 1, 1);
        n_vec++;
        if (rise_o !== 4'b0101) begin
            n_bad++;
            $display("FAIL dir_x_rise got %b want 0101", rise_o);
        end
        cycle(4'b111z, 0, 1, 1);
        n_vec++;
        if (rise_o !== m_rise || fall_o !== m_fall) begin
            n_bad++;
            $display("FAIL dir_z got %b/%b want %b/%b", rise_o, fall_o, m_rise, m_fall);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'hF0;
        exp_d[1] = 8'h0F;
        exp_d[2] = 8'hF0;
        exp_d[3] = 8'h0F;
        cycle(4'b0000, 0, 0, 0);
        cycle(4'b0000, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle((i % 2 == 0) ? 4'b1111 : 4'b0000, 0, 0, 1);
        n_vec++;
        if (evt_overflow_o !== 1'b1 || evt_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_flag got o=%b v=%b want 1 1", evt_overflow_o, evt_valid_o);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (evt_valid_o !== 1'b1 || evt_data_o !== exp_d[i]) begin
                n_bad++;
                $display("FAIL ovf_drain%0d got v=%b d=%h want 1 %h", i, evt_valid_o, evt_data_o, exp_d[i]);
            end
            cycle(4'b1111, 0, 1, 1);
        end
        n_vec++;
        if (evt_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_empty got v=%b want 0", evt_valid_o);
        end
    endtask

    task automatic test_full_push_pop();
        int pops;
        cycle(4'b0000, 0, 0, 0);
        cycle(4'b0000, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle((i % 2 == 0) ? 4'b0011 : 4'b0000, 0, 0, 1);
        cycle(4'b0011, 0, 1, 1);
        n_vec++;
        if (evt_overflow_o !== 1'b0 || evt_data_o !== 8'h03) begin
            n_bad++;
            $display("FAIL fpp_state got o=%b d=%h want 0 03", evt_overflow_o, evt_data_o);
        end
        pops = 0;
        for (int k = 0; k < 8 && evt_valid_o === 1'b1; k++) begin
            cycle(4'b0011, 0, 1, 1);
            pops++;
        end
        n_vec++;
        if (pops != 4 || evt_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL fpp_occupancy got %0d pops want 4", pops);
        end
    endtask

    task automatic test_clear();
        cycle(4'b0000, 0, 0, 0);
        cycle(4'b0000, 0, 0, 1);
        for (int i = 0; i < 6; i++) cycle((i % 2 == 0) ? 4'b0101 : 4'b0000, 0, 0, 1);
        cycle(4'b0101, 1, 1, 1);
        n_vec++;
        if (evt_valid_o !== 1'b0 || rise_cnt_o !== 8'd0 || evt_overflow_o !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_state got v=%b cnt=%0d o=%b want 0 0 0", evt_valid_o, rise_cnt_o, evt_overflow_o);
        end
        n_vec++;
        if (rise_o !== 4'b0101 || rise_o !== m_rise) begin
            n_bad++;
            $display("FAIL clr_masks got %b want 0101", rise_o);
        end
        cycle(4'b0000, 0, 0, 1);
        n_vec++;
        if (evt_valid_o !== 1'b1 || evt_data_o !== 8'h05) begin
            n_bad++;
            $display("FAIL clr_after got v=%b d=%h want 1 05", evt_valid_o, evt_data_o);
        end
    endtask

    task automatic test_reset_mid_and_saturate();
        for (int i = 0; i < 6; i++) cycle((i % 2 == 0) ? 4'b1111 : 4'b0000, 0, 0, 1);
        cycle(4'b1111, 0, 0, 0);
        n_vec++;
        if ({rise_o, fall_o, any_rise_o, any_fall_o, rise_cnt_o, evt_valid_o, evt_overflow_o} !== 20'b0) begin
            n_bad++;
            $display("FAIL mid_reset got r=%b f=%b cnt=%0d v=%b o=%b want 0", rise_o, fall_o, rise_cnt_o, evt_valid_o, evt_overflow_o);
        end
        cycle(4'b0000, 0, 1, 1);
        n_vec++;
        if ({rise_o, fall_o} !== 8'b0) begin
            n_bad++;
            $display("FAIL mid_release got %b/%b want 0000/0000", rise_o, fall_o);
        end
        for (int i = 0; i < 300; i++) begin
            cycle(4'b0001, 0, 1, 1);
            cycle(4'b0000, 0, 1, 1);
        end
        n_vec++;
        if (rise_cnt_o !== 8'd255) begin
            n_bad++;
            $display("FAIL saturate got %0d want 255", rise_cnt_o);
        end
    endtask

    task automatic test_random();
        cycle(4'b0000, 0, 0, 0);
        for (int n = 0; n < 500; n++) begin
            cycle(4'($urandom()), ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 63) != 0));
            n_vec++;
            if (rise_o !== m_rise || fall_o !== m_fall) begin
                n_bad++;
                $display("FAIL rnd_masks n=%0d got %b/%b want %b/%b", n, rise_o, fall_o, m_rise, m_fall);
            end
            n_vec++;
            if (any_rise_o !== (m_rise != 0) || any_fall_o !== (m_fall != 0)) begin
                n_bad++;
                $display("FAIL rnd_any n=%0d got %b/%b", n, any_rise_o, any_fall_o);
            end
            n_vec++;
            if (rise_cnt_o !== CNT_W'(m_cnt)) begin
                n_bad++;
                $display("FAIL rnd_cnt n=%0d got %0d want %0d", n, rise_cnt_o, m_cnt);
            end
            n_vec++;
            if (evt_valid_o !== (m_q.size() != 0) || evt_overflow_o !== m_ovf) begin
                n_bad++;
                $display("FAIL rnd_q n=%0d got v=%b o=%b want %b %b", n, evt_valid_o, evt_overflow_o, m_q.size() != 0, m_ovf);
            end
            if (m_q.size() != 0) begin
                n_vec++;
                if (evt_data_o !== m_q[0]) begin
                    n_bad++;
                    $display("FAIL rnd_data n=%0d got %h want %h", n, evt_data_o, m_q[0]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clr_i = 1'b0;
        evt_ready_i = 1'b0;
        sig_in = '0;
        m_prev = '0;
        m_pv = 0;
        m_cnt = 0;
        m_ovf = 0;
        m_rise = '0;
        m_fall = '0;
        test_reset();
        test_directed();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_reset_mid_and_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
